// File: rtl/cd_pkg.sv
// Shared definitions for the Neo CD sector cache / DMA block.
// Holds sector geometry, the default destination and the FSM state types.
package cd_pkg;
    localparam int          CD_SECTOR_WORDS = 1024;
    localparam logic [23:0] CD_DEST_BASE    = 24'h111204;
    localparam int          CACHE_AW        = 11;

    typedef enum logic {
        F_IDLE,
        F_FILL
    } fill_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD,
        C_WR,
        C_END
    } copy_state_t;

    // DBC holds byte count minus one; convert to a word count, saturated at one sector.
    function automatic logic [11:0] dbc_words(input logic [11:0] dbc, input logic [11:0] cap);
        logic [11:0] n;
        n = {1'b0, dbc[11:1]} + 12'd1;
        return (n > cap) ? cap : n;
    endfunction
endpackage

// File: rtl/cd_sector_dma_if.sv
// HPS fill and 68k-side DMA signals of the sector cache block.
// master = the cd_sector_dma block, slave = whatever drives it.
interface cd_sector_dma_if;
    logic        NEXT_SECTOR_REQ;
    logic        HPS_REQ;
    logic        HPS_WR;
    logic [15:0] HPS_DATA;
    logic        SECTOR_READY;
    logic        DMA_START;
    logic [11:0] DMA_DBC;
    logic [23:0] DMA_ADDR;
    logic [15:0] DMA_DOUT;
    logic        DMA_WR;
    logic        DMA_ACK;
    logic        DMA_DONE;
    logic        MSF_INC;
    logic        BUSY;

    modport master (
        input  NEXT_SECTOR_REQ, HPS_WR, HPS_DATA, DMA_START, DMA_DBC, DMA_ACK,
        output HPS_REQ, SECTOR_READY, DMA_ADDR, DMA_DOUT, DMA_WR, DMA_DONE, MSF_INC, BUSY
    );

    modport slave (
        output NEXT_SECTOR_REQ, HPS_WR, HPS_DATA, DMA_START, DMA_DBC, DMA_ACK,
        input  HPS_REQ, SECTOR_READY, DMA_ADDR, DMA_DOUT, DMA_WR, DMA_DONE, MSF_INC, BUSY
    );
endinterface

// File: rtl/cd_sector_ram.sv
// Two-bank sector cache: simple dual-port RAM, write port for fill,
// registered read port for copy (maps onto a block RAM).
module cd_sector_ram
    import cd_pkg::*;
#(
    parameter int AW = CACHE_AW,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cd_sector_dma.sv
// Ping-pong sector cache filled from the HPS and copied to 68k memory.
// Fill and copy FSMs run concurrently; the fill never targets the bank being copied.
module cd_sector_dma
    import cd_pkg::*;
#(
    parameter int          SECTOR_WORDS = CD_SECTOR_WORDS,
    parameter logic [23:0] DEST_BASE    = CD_DEST_BASE
) (
    input  logic             CLK_12M,
    input  logic             nRESET,
    cd_sector_dma_if.master  bus
);
    localparam int          IDX_W    = $clog2(SECTOR_WORDS);
    localparam int          AW       = IDX_W + 1;
    localparam int          CW       = IDX_W + 1;
    localparam logic [11:0] WORD_CAP = 12'(SECTOR_WORDS);

    fill_state_t f_state, f_next;
    copy_state_t c_state, c_next;

    logic [IDX_W-1:0] wptr, rptr;
    logic [CW-1:0]    cnt;
    logic             fill_bank, ready_bank, copy_bank, valid, req_pend;
    logic             fill_start, fill_last, ram_we, copy_active;
    logic [AW-1:0]    raddr;
    logic [15:0]      rdata;

    logic             hps_req, sector_ready, dma_wr, dma_done, msf_inc;
    logic [23:0]      dma_addr;
    logic [15:0]      dma_dout;

    assign copy_active = (c_state != C_IDLE);

    cd_sector_ram #(.AW(AW), .DW(16)) u_ram (
        .clk   (CLK_12M),
        .we    (ram_we),
        .waddr ({fill_bank, wptr}),
        .wdata (bus.HPS_DATA),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        f_next     = f_state;
        fill_start = 1'b0;
        fill_last  = 1'b0;
        ram_we     = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (req_pend && !(copy_active && (fill_bank == copy_bank))) begin
                    fill_start = 1'b1;
                    f_next     = F_FILL;
                end
            end
            F_FILL: begin
                if (bus.HPS_WR) begin
                    ram_we = 1'b1;
                    if (wptr == IDX_W'(SECTOR_WORDS - 1)) begin
                        fill_last = 1'b1;
                        f_next    = F_IDLE;
                    end
                end
            end
            default: f_next = F_IDLE;
        endcase
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            f_state      <= F_IDLE;
            wptr         <= '0;
            fill_bank    <= 1'b0;
            ready_bank   <= 1'b0;
            valid        <= 1'b0;
            req_pend     <= 1'b0;
            hps_req      <= 1'b0;
            sector_ready <= 1'b0;
        end else begin
            f_state  <= f_next;
            hps_req  <= fill_start;
            // A new request arriving as the pending one is consumed stays pending.
            req_pend <= bus.NEXT_SECTOR_REQ | (req_pend & ~fill_start);
            if (fill_start) begin
                sector_ready <= 1'b0;
                wptr         <= '0;
            end
            if (ram_we)
                wptr <= wptr + IDX_W'(1);
            if (fill_last) begin
                ready_bank   <= fill_bank;
                fill_bank    <= ~fill_bank;
                valid        <= 1'b1;
                sector_ready <= 1'b1;
            end
        end
    end

    // Read address is issued one cycle ahead so C_RD sees the word it needs.
    always_comb begin
        c_next = c_state;
        raddr  = {copy_bank, rptr};
        case (c_state)
            C_IDLE: begin
                if (bus.DMA_START) begin
                    c_next = valid ? C_RD : C_END;
                    raddr  = {ready_bank, IDX_W'(0)};
                end
            end
            C_RD: c_next = C_WR;
            C_WR: begin
                if (bus.DMA_ACK) begin
                    c_next = (cnt == CW'(1)) ? C_END : C_RD;
                    raddr  = {copy_bank, rptr + IDX_W'(1)};
                end
            end
            C_END:   c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            c_state   <= C_IDLE;
            copy_bank <= 1'b0;
            rptr      <= '0;
            cnt       <= '0;
            dma_addr  <= DEST_BASE;
            dma_dout  <= '0;
            dma_wr    <= 1'b0;
            dma_done  <= 1'b0;
            msf_inc   <= 1'b0;
        end else begin
            c_state <= c_next;
            msf_inc <= 1'b0;
            case (c_state)
                C_IDLE: begin
                    if (bus.DMA_START) begin
                        dma_done  <= 1'b0;
                        copy_bank <= ready_bank;
                        rptr      <= '0;
                        dma_addr  <= DEST_BASE;
                        cnt       <= CW'(dbc_words(bus.DMA_DBC, WORD_CAP));
                    end
                end
                C_RD: begin
                    dma_dout <= rdata;
                    dma_wr   <= 1'b1;
                end
                C_WR: begin
                    if (bus.DMA_ACK) begin
                        dma_wr   <= 1'b0;
                        dma_addr <= dma_addr + 24'd2;
                        rptr     <= rptr + IDX_W'(1);
                        cnt      <= cnt - CW'(1);
                    end
                end
                C_END: begin
                    dma_done <= 1'b1;
                    msf_inc  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.HPS_REQ      = hps_req;
    assign bus.SECTOR_READY = sector_ready;
    assign bus.DMA_ADDR     = dma_addr;
    assign bus.DMA_DOUT     = dma_dout;
    assign bus.DMA_WR       = dma_wr;
    assign bus.DMA_DONE     = dma_done;
    assign bus.MSF_INC      = msf_inc;
    assign bus.BUSY         = (f_state != F_IDLE) | copy_active;
endmodule

// File: tb/tb_cd_sector_dma.sv
// Bench for cd_sector_dma: table of copy vectors plus hand-written fill,
// overlap, empty-cache and asynchronous-reset sequences.
module tb_cd_sector_dma;
    localparam logic [23:0] DEST = 24'h111204;

    logic clk = 1'b0;
    logic nRESET;
    always #5 clk = ~clk;

    cd_sector_dma_if bus();

    cd_sector_dma dut (
        .CLK_12M (clk),
        .nRESET  (nRESET),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor on the falling edge: pulse counters and accepted-write log.
    int          hreq_cnt = 0, msf_cnt = 0, wr_cycles = 0, stable_err = 0;
    logic [23:0] addr_q[$];
    logic [15:0] data_q[$];
    logic        prev_wait = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [15:0] prev_dout = '0;

    always @(negedge clk) begin
        if (bus.HPS_REQ === 1'b1) hreq_cnt <= hreq_cnt + 1;
        if (bus.MSF_INC === 1'b1) msf_cnt <= msf_cnt + 1;
        if (bus.DMA_WR === 1'b1) begin
            wr_cycles <= wr_cycles + 1;
            if (prev_wait && (bus.DMA_ADDR !== prev_addr || bus.DMA_DOUT !== prev_dout))
                stable_err <= stable_err + 1;
            if (bus.DMA_ACK === 1'b1) begin
                addr_q.push_back(bus.DMA_ADDR);
                data_q.push_back(bus.DMA_DOUT);
            end
        end
        prev_wait <= (bus.DMA_WR === 1'b1) && (bus.DMA_ACK !== 1'b1);
        prev_addr <= bus.DMA_ADDR;
        prev_dout <= bus.DMA_DOUT;
    end

    // Acknowledge driver: delay 0 means ACK tied high, else ACK after dly cycles of DMA_WR.
    int ack_delay = 0;
    initial begin
        int wc;
        wc = 0;
        bus.DMA_ACK = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_delay == 0) bus.DMA_ACK = 1'b1;
            else if (bus.DMA_ACK) begin
                bus.DMA_ACK = 1'b0;
                wc = 0;
            end else if (bus.DMA_WR === 1'b1) begin
                wc++;
                if (wc >= ack_delay) bus.DMA_ACK = 1'b1;
            end else wc = 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_nsr();
        bus.NEXT_SECTOR_REQ = 1'b1;
        tick();
        bus.NEXT_SECTOR_REQ = 1'b0;
    endtask

    task automatic wait_hreq(input string nm);
        int n;
        n = 0;
        while (bus.HPS_REQ !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(nm, bus.HPS_REQ, 1);
    endtask

    task automatic fill(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.HPS_WR   = 1'b1;
            bus.HPS_DATA = base + 16'(i);
            tick();
        end
        bus.HPS_WR = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " HPS_REQ"},      bus.HPS_REQ,      0);
        chk({nm, " SECTOR_READY"}, bus.SECTOR_READY, 0);
        chk({nm, " DMA_ADDR"},     bus.DMA_ADDR,     DEST);
        chk({nm, " DMA_DOUT"},     bus.DMA_DOUT,     0);
        chk({nm, " DMA_WR"},       bus.DMA_WR,       0);
        chk({nm, " DMA_DONE"},     bus.DMA_DONE,     0);
        chk({nm, " MSF_INC"},      bus.MSF_INC,      0);
        chk({nm, " BUSY"},         bus.BUSY,         0);
    endtask

    int q0, msf0, wrc0, cur_dly;

    task automatic start_copy(input logic [11:0] dbc, input int dly);
        ack_delay = dly;
        cur_dly   = dly;
        q0        = addr_q.size();
        msf0      = msf_cnt;
        wrc0      = wr_cycles;
        bus.DMA_DBC   = dbc;
        bus.DMA_START = 1'b1;
        tick();
        bus.DMA_START = 1'b0;
        chk("done cleared by start", bus.DMA_DONE, 0);
    endtask

    task automatic finish_copy(input string nm, input int words, input logic [23:0] last,
                               input logic [15:0] base);
        int n, got, bad_a, bad_d, exp_wrc;
        logic [23:0] got_last;
        n = 0; bad_a = 0; bad_d = 0;
        while (bus.DMA_DONE !== 1'b1 && n < 6000) begin
            tick();
            n++;
        end
        chk({nm, " done"}, bus.DMA_DONE, 1);
        if (cur_dly == 0) chk({nm, " throughput"}, 32'(n <= 2 * words + 2), 1);
        tick();
        tick();
        got = addr_q.size() - q0;
        chk({nm, " writes"}, got, words);
        chk({nm, " msf pulses"}, msf_cnt - msf0, 1);
        exp_wrc = words * ((cur_dly == 0) ? 1 : cur_dly);
        chk({nm, " wr cycles"}, wr_cycles - wrc0, exp_wrc);
        for (int i = 0; i < got; i++) begin
            if (addr_q[q0 + i] !== DEST + 24'(2 * i)) bad_a++;
            if (data_q[q0 + i] !== base + 16'(i))     bad_d++;
        end
        chk({nm, " addr errs"}, bad_a, 0);
        chk({nm, " data errs"}, bad_d, 0);
        got_last = (got > 0) ? addr_q[q0 + got - 1] : 24'h0;
        chk({nm, " last addr"}, got_last, last);
        chk({nm, " end addr"}, bus.DMA_ADDR, DEST + 24'(2 * words));
        chk({nm, " busy"}, bus.BUSY, 0);
    endtask

    typedef struct {
        logic [11:0] dbc;
        int          dly;
        int          words;
        logic [23:0] last;
    } vec_t;

    vec_t vt[5];
    int   h0, n;

    initial begin
        vt[0] = '{12'h7FF, 0, 1024, 24'h111A02};
        vt[1] = '{12'h00F, 0,    8, 24'h111212};
        vt[2] = '{12'hFFF, 0, 1024, 24'h111A02};
        vt[3] = '{12'h000, 1,    1, 24'h111204};
        vt[4] = '{12'h003, 2,    2, 24'h111206};

        bus.NEXT_SECTOR_REQ = 1'b0;
        bus.HPS_WR    = 1'b0;
        bus.HPS_DATA  = '0;
        bus.DMA_START = 1'b0;
        bus.DMA_DBC   = '0;
        nRESET = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        nRESET = 1'b1;
        tick();

        // Copy with nothing ever cached.
        start_copy(12'h7FF, 0);
        finish_copy("empty", 0, 24'h0, 16'h0);

        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        tick();

        // First fill: words 0000..03FF into bank A.
        h0 = hreq_cnt;
        pulse_nsr();
        wait_hreq("fill1 req");
        chk("fill1 busy", bus.BUSY, 1);
        fill(16'h0000, 1023);
        chk("fill1 ready before last", bus.SECTOR_READY, 0);
        fill(16'h03FF, 1);
        chk("fill1 ready after last", bus.SECTOR_READY, 1);
        chk("fill1 idle", bus.BUSY, 0);
        tick();
        chk("fill1 one req", hreq_cnt - h0, 1);

        for (int k = 0; k < 5; k++) begin
            start_copy(vt[k].dbc, vt[k].dly);
            finish_copy($sformatf("vec%0d", k), vt[k].words, vt[k].last, 16'h0000);
        end

        // Slow copy of A while B fills; second request must wait for the copy.
        start_copy(12'h7FF, 3);
        pulse_nsr();
        wait_hreq("ovl fill B req");
        fill(16'h1000, 1024);
        chk("ovl B ready", bus.SECTOR_READY, 1);
        chk("ovl copy running", bus.BUSY, 1);
        pulse_nsr();
        h0 = hreq_cnt;
        n = 0;
        while (bus.DMA_DONE !== 1'b1 && n < 6000) begin
            tick();
            n++;
        end
        chk("ovl no req during copy", hreq_cnt - h0, 0);
        wait_hreq("ovl fill A req");
        fill(16'h2000, 1024);
        finish_copy("ovl copy A", 1024, 24'h111A02, 16'h0000);
        chk("ovl write hold", stable_err, 0);
        start_copy(12'h00F, 0);
        finish_copy("ovl new A", 8, 24'h111212, 16'h2000);

        // Asynchronous reset mid-fill.
        pulse_nsr();
        wait_hreq("rst fill req");
        fill(16'h4000, 500);
        chk("rst fill busy", bus.BUSY, 1);
        #2 nRESET = 1'b0;
        #1 chk_reset("rst mid-fill");
        tick();
        nRESET = 1'b1;
        tick();

        // Asynchronous reset mid-copy while DMA_WR is held.
        pulse_nsr();
        wait_hreq("rst copy fill req");
        fill(16'h5000, 1024);
        start_copy(12'h7FF, 3);
        n = 0;
        while (bus.DMA_WR !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("rst copy wr high", bus.DMA_WR, 1);
        #2 nRESET = 1'b0;
        #1 chk_reset("rst mid-copy");
        tick();
        nRESET = 1'b1;
        tick();

        pulse_nsr();
        wait_hreq("post-rst req");
        fill(16'h6000, 1024);
        start_copy(12'h7FF, 0);
        finish_copy("post-rst copy", 1024, 24'h111A02, 16'h6000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
